// File: rtl/addsub_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one 4-bit carry-lookahead slice per nibble, LSB first.
// Result valid NSLICE clocks after accept; result and flags are held in DONE until out_ready, and in_ready is low outside IDLE.
module addsub_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int NSLICE = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic [4:0]         slice_res;
  logic [WIDTH-1:0]   sum_nxt;

  // The shared slice: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign slice_res = cla4(opa_q[4*int'(idx_q) +: 4], opb_q[4*int'(idx_q) +: 4], carry_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    sum_nxt = sum_q;
    sum_nxt[4*int'(idx_q) +: 4] = slice_res[3:0];

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_nxt;
        carry_d = slice_res[4];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Overflow is judged on the effective operands, i.e. after B inversion for subtract.
          cout_d  = slice_res[4];
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sum_nxt[WIDTH-1] != opa_q[WIDTH-1]);
          zero_d  = ~|sum_nxt;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl: directed vectors push expected results, a negedge monitor pops on each handshake.
module tb_addsub_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  addsub_seq_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every result handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sum=%h with no pending operation", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (sum !== e.s || cout !== e.c || ovf !== e.o || zero !== e.z) begin
          errors++;
          $display("FAIL result: got sum=%h c=%b v=%b z=%b expected sum=%h c=%b v=%b z=%b",
                   sum, cout, ovf, zero, e.s, e.c, e.o, e.z);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, issues one op, pushes its expectation and checks the accept-to-valid latency.
  task automatic start(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    int n;
    int lat;
    exp_t e;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = av;
    b = bv;
    sub = sv;
    in_valid = 1'b1;
    e.s = es; e.c = ec; e.o = eo; e.z = ez;
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, 32'd4);
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                        input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    start(av, bv, sv, es, ec, eo, ez);
    step();
    chk("idle_after_handshake", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] held_sum;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    sub       = 1'b0;
    out_ready = 1'b1;

    // Reset behaviour
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    chk("rst_in_ready2", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic add, borrow/sign and carry/overflow cases
    run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op(16'h1000, 16'h2000, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held while a new op is offered and must not be captured
    out_ready = 1'b0;
    start(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    held_sum = sum;
    chk("bp_sum_initial", {16'd0, held_sum}, 32'h3333);
    a = 16'hAAAA;
    b = 16'h1111;
    sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum", {16'd0, sum}, 32'h3333);
      chk("bp_flags", {29'd0, cout, ovf, zero}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'b10);
    run_op(16'hAAAA, 16'h1111, 1'b0, 16'hBBBB, 1'b0, 1'b0, 1'b0);

    // Reset during RUN at slice index 2: the op is dropped with no result
    a = 16'h4321;
    b = 16'h1234;
    sub = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    run_op(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
